md_issue_ctrl: RTL and testbench
================================

MD_ISSUE_CTRL -- requirements
Module: md_issue_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, giving the max wait cycles for md_resultRDY (used only with MD_TIMEOUT_EN).
REQ-002 SHALL have parameter RSTATUS_REG, default 30, giving the register index written on exception.
REQ-003 SHALL use one clock and an asynchronous active-low reset: clock (in, 1, rising-edge clock) and clrn (in, 1, async active-low clear).
REQ-004 SHALL have issue_valid (in, 1): decode stage presents a mult/div instruction.
REQ-005 SHALL have is_mult and is_div (in, 1 each): operation select.
REQ-006 SHALL have operandA and operandB (in, 32 each) and dest_reg (in, 5).
REQ-007 SHALL have md_operandA and md_operandB (out, 32 each): registered operands to multdiv, held stable while busy.
REQ-008 SHALL have ctrl_MULT and ctrl_DIV (out, 1 each): one-cycle start pulses to multdiv.
REQ-009 SHALL have md_result (in, 32), md_exception (in, 1) and md_resultRDY (in, 1), all from multdiv.
REQ-010 SHALL have stall (out, 1): freezes the upstream pipeline.
REQ-011 SHALL have wb_valid (out, 1), wb_reg (out, 5), wb_data (out, 32) and wb_exception (out, 1): writeback port.

Function
REQ-012 SHALL implement FSM states IDLE, START, BUSY, DONE.
REQ-013 SHALL accept in IDLE when issue_valid & (is_mult ^ is_div): latch operands, op and dest_reg; next state START.
REQ-014 SHALL ignore issue_valid with is_mult & is_div, or with neither set: no latch, no pulse, stall low.
REQ-015 SHALL drive exactly one of ctrl_MULT/ctrl_DIV high for the single START cycle, then go to BUSY.
REQ-016 SHALL ignore md_resultRDY during START, because it can be stale from the previous op.
REQ-017 SHALL, in BUSY on md_resultRDY=1, capture md_result/md_exception and go to DONE.
REQ-018 SHALL, in DONE, hold wb_valid=1 for exactly one cycle, then return to IDLE; a new accept is possible the following cycle.
REQ-019 SHALL drive wb_reg=dest_reg, wb_data=captured result and wb_exception=0 when no exception was captured.
REQ-020 SHALL drive wb_reg=RSTATUS_REG, wb_exception=1 and wb_data=4 (mult) or 5 (div) when an exception was captured.
REQ-021 SHALL drive stall combinationally as (IDLE & accept) | START | BUSY; stall SHALL be low in DONE.
REQ-022 SHALL ignore issue_valid in START, BUSY and DONE.
REQ-023 SHALL give a minimum latency from accept to wb_valid of 3 cycles plus multdiv latency.

Reset
REQ-024 SHALL, on clrn=0 (async), force state to IDLE and drive all outputs and registers to 0.
REQ-025 SHALL, on reset mid-START/BUSY, abandon the operation: no writeback and no further pulse.

Configuration
REQ-026 SHALL, with MD_TIMEOUT_EN defined, count BUSY cycles.
REQ-027 SHALL, with MD_TIMEOUT_EN defined, go to DONE when the count reaches TIMEOUT_CYCLES without md_resultRDY, driving wb_reg=RSTATUS_REG, wb_data=6 and wb_exception=1.
REQ-028 SHALL, without MD_TIMEOUT_EN, omit the counter and wait in BUSY indefinitely.

Structure
REQ-029 SHALL place the state encoding, exception codes (4, 5, 6) and RSTATUS default in shared package md_pkg.
REQ-030 SHALL implement the timeout counter as sub-module md_watchdog (clock, clrn, clear, run, expired), instantiated only under MD_TIMEOUT_EN.

Verification
REQ-031 SHALL cover: issue mult 6*7, dest 3 -> one ctrl_MULT pulse the cycle after accept; on RDY, wb_valid with wb_reg=3, wb_data=42, wb_exception=0.
REQ-032 SHALL cover: issue div 100/0, dest 7 with md_exception=1 -> wb_reg=30, wb_data=5, wb_exception=1.
REQ-033 SHALL cover: mult 0x40000000*4 with overflow -> wb_reg=30, wb_data=4; stall high from accept until the cycle before DONE.
REQ-034 SHALL cover: is_mult=is_div=1 -> no ctrl pulses, stall=0, state stays IDLE.
REQ-035 SHALL cover: clrn pulsed low mid-BUSY -> all outputs 0 immediately; later RDY -> no wb_valid.
REQ-036 SHALL cover, with MD_TIMEOUT_EN: RDY held low 64 cycles -> wb_valid with wb_reg=30, wb_data=6; back-to-back issue accepted after DONE.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the mult/div issue controller: FSM encoding,
// writeback exception codes and the default status register index.
package md_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_BUSY  = 2'd2,
        S_DONE  = 2'd3
    } md_state_t;

    localparam logic [31:0] EXC_MULT    = 32'd4;
    localparam logic [31:0] EXC_DIV     = 32'd5;
    localparam logic [31:0] EXC_TIMEOUT = 32'd6;

    localparam int unsigned RSTATUS_DEFAULT = 30;

endpackage

// File: rtl/md_watchdog.sv
// Counts consecutive BUSY cycles and flags expiry on the TIMEOUT_CYCLES-th one.
// Only instantiated when MD_TIMEOUT_EN is defined.
module md_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 64
) (
    input  logic clock,
    input  logic clrn,
    input  logic clear,
    input  logic run,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

    // count still holds the number of earlier run cycles, so compare against N-1
    assign expired = run && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/writeback sequencer between decode and the multdiv unit.
// Optional busy watchdog enabled by defining MD_TIMEOUT_EN.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned RSTATUS_REG    = RSTATUS_DEFAULT
) (
    input  logic        clock,
    input  logic        clrn,
    input  logic        issue_valid,
    input  logic        is_mult,
    input  logic        is_div,
    input  logic [31:0] operandA,
    input  logic [31:0] operandB,
    input  logic [4:0]  dest_reg,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall,
    output logic        wb_valid,
    output logic [4:0]  wb_reg,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    md_state_t   state, state_next;
    logic        accept;
    logic        wd_expired;
    logic        op_mult_q;
    logic [4:0]  dest_q;
    logic [31:0] result_q;
    logic        exc_q;
    logic        tmo_q;

    assign accept = issue_valid & (is_mult ^ is_div);

`ifdef MD_TIMEOUT_EN
    md_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .clrn   (clrn),
        .clear  (state != S_BUSY),
        .run    (state == S_BUSY),
        .expired(wd_expired)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign wd_expired         = 1'b0;
`endif

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            S_IDLE:  if (accept) state_next = S_START;
            S_START: state_next = S_BUSY;
            S_BUSY:  if (md_resultRDY || wd_expired) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clrn) begin
        if (!clrn) begin
            md_operandA <= '0;
            md_operandB <= '0;
            op_mult_q   <= 1'b0;
            dest_q      <= '0;
            result_q    <= '0;
            exc_q       <= 1'b0;
            tmo_q       <= 1'b0;
        end else begin
            if (state == S_IDLE && accept) begin
                md_operandA <= operandA;
                md_operandB <= operandB;
                op_mult_q   <= is_mult;
                dest_q      <= dest_reg;
            end
            // A real result wins over a watchdog expiry landing on the same cycle
            if (state == S_BUSY) begin
                if (md_resultRDY) begin
                    result_q <= md_result;
                    exc_q    <= md_exception;
                    tmo_q    <= 1'b0;
                end else if (wd_expired) begin
                    result_q <= '0;
                    exc_q    <= 1'b0;
                    tmo_q    <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        ctrl_MULT    = 1'b0;
        ctrl_DIV     = 1'b0;
        stall        = 1'b0;
        wb_valid     = 1'b0;
        wb_reg       = '0;
        wb_data      = '0;
        wb_exception = 1'b0;
        unique case (state)
            S_IDLE:  stall = accept;
            S_START: begin
                stall     = 1'b1;
                ctrl_MULT = op_mult_q;
                ctrl_DIV  = ~op_mult_q;
            end
            S_BUSY:  stall = 1'b1;
            S_DONE:  begin
                wb_valid = 1'b1;
                if (tmo_q) begin
                    wb_reg       = 5'(RSTATUS_REG);
                    wb_data      = EXC_TIMEOUT;
                    wb_exception = 1'b1;
                end else if (exc_q) begin
                    wb_reg       = 5'(RSTATUS_REG);
                    wb_data      = op_mult_q ? EXC_MULT : EXC_DIV;
                    wb_exception = 1'b1;
                end else begin
                    wb_reg  = dest_q;
                    wb_data = result_q;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Directed self-checking bench for md_issue_ctrl; the timeout scenario
// is included only when MD_TIMEOUT_EN is defined.
module tb_md_issue_ctrl;

    logic        clock;
    logic        clrn;
    logic        issue_valid;
    logic        is_mult;
    logic        is_div;
    logic [31:0] operandA;
    logic [31:0] operandB;
    logic [4:0]  dest_reg;
    logic [31:0] md_operandA;
    logic [31:0] md_operandB;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] md_result;
    logic        md_exception;
    logic        md_resultRDY;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;
    logic        wb_exception;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    md_issue_ctrl #(
        .TIMEOUT_CYCLES(64),
        .RSTATUS_REG   (30)
    ) dut (
        .clock       (clock),
        .clrn        (clrn),
        .issue_valid (issue_valid),
        .is_mult     (is_mult),
        .is_div      (is_div),
        .operandA    (operandA),
        .operandB    (operandB),
        .dest_reg    (dest_reg),
        .md_operandA (md_operandA),
        .md_operandB (md_operandB),
        .ctrl_MULT   (ctrl_MULT),
        .ctrl_DIV    (ctrl_DIV),
        .md_result   (md_result),
        .md_exception(md_exception),
        .md_resultRDY(md_resultRDY),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_reg      (wb_reg),
        .wb_data     (wb_data),
        .wb_exception(wb_exception)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_issue(input logic m, input logic d, input logic [31:0] a,
                               input logic [31:0] b, input logic [4:0] r);
        issue_valid = 1'b1;
        is_mult     = m;
        is_div      = d;
        operandA    = a;
        operandB    = b;
        dest_reg    = r;
    endtask

    initial begin
        clrn         = 1'b0;
        issue_valid  = 1'b0;
        is_mult      = 1'b0;
        is_div       = 1'b0;
        operandA     = '0;
        operandB     = '0;
        dest_reg     = '0;
        md_result    = '0;
        md_exception = 1'b0;
        md_resultRDY = 1'b0;

        #12;
        check("rst_opA",   md_operandA, 32'd0);
        check("rst_opB",   md_operandB, 32'd0);
        check("rst_mult",  ctrl_MULT,   32'd0);
        check("rst_div",   ctrl_DIV,    32'd0);
        check("rst_stall", stall,       32'd0);
        check("rst_wbv",   wb_valid,    32'd0);
        check("rst_wbreg", wb_reg,      32'd0);
        check("rst_wbdat", wb_data,     32'd0);
        check("rst_wbexc", wb_exception, 32'd0);
        clrn = 1'b1;
        step();

        // mult 6*7 -> r3, with a stale RDY during START
        drive_issue(1'b1, 1'b0, 32'd6, 32'd7, 5'd3);
        #1;
        check("t1_acc_stall", stall, 32'd1);
        check("t1_acc_mult",  ctrl_MULT, 32'd0);
        step();
        issue_valid  = 1'b0;
        md_resultRDY = 1'b1;
        md_result    = 32'd99;
        #1;
        check("t1_st_mult", ctrl_MULT, 32'd1);
        check("t1_st_div",  ctrl_DIV, 32'd0);
        check("t1_st_opA",  md_operandA, 32'd6);
        check("t1_st_opB",  md_operandB, 32'd7);
        step();
        md_resultRDY = 1'b0;
        #1;
        check("t1_busy_wbv",   wb_valid, 32'd0);
        check("t1_busy_mult",  ctrl_MULT, 32'd0);
        check("t1_busy_stall", stall, 32'd1);
        md_resultRDY = 1'b1;
        md_result    = 32'd42;
        step();
        md_resultRDY = 1'b0;
        #1;
        check("t1_wbv",   wb_valid, 32'd1);
        check("t1_wbreg", wb_reg, 32'd3);
        check("t1_wbdat", wb_data, 32'd42);
        check("t1_wbexc", wb_exception, 32'd0);
        check("t1_done_stall", stall, 32'd0);

        // div 100/0 -> exception; issue presented during DONE must wait a cycle
        drive_issue(1'b0, 1'b1, 32'd100, 32'd0, 5'd7);
        #1;
        check("t2_done_stall", stall, 32'd0);
        step();
        check("t2_wbv_low",   wb_valid, 32'd0);
        check("t2_acc_stall", stall, 32'd1);
        step();
        drive_issue(1'b1, 1'b0, 32'd1, 32'd2, 5'd4);
        #1;
        check("t2_st_div",  ctrl_DIV, 32'd1);
        check("t2_st_mult", ctrl_MULT, 32'd0);
        check("t2_st_opA",  md_operandA, 32'd100);
        check("t2_st_opB",  md_operandB, 32'd0);
        step();
        check("t2_busy_div", ctrl_DIV, 32'd0);
        check("t2_busy_opA", md_operandA, 32'd100);
        issue_valid  = 1'b0;
        md_resultRDY = 1'b1;
        md_exception = 1'b1;
        md_result    = 32'd0;
        step();
        md_resultRDY = 1'b0;
        md_exception = 1'b0;
        check("t2_wbv",   wb_valid, 32'd1);
        check("t2_wbreg", wb_reg, 32'd30);
        check("t2_wbdat", wb_data, 32'd5);
        check("t2_wbexc", wb_exception, 32'd1);
        step();

        // mult overflow; stall profile across the whole operation
        drive_issue(1'b1, 1'b0, 32'h4000_0000, 32'd4, 5'd9);
        #1;
        check("t3_acc_stall", stall, 32'd1);
        step();
        issue_valid = 1'b0;
        check("t3_st_stall", stall, 32'd1);
        check("t3_st_mult",  ctrl_MULT, 32'd1);
        step();
        check("t3_b1_stall", stall, 32'd1);
        step();
        check("t3_b2_stall", stall, 32'd1);
        md_resultRDY = 1'b1;
        md_exception = 1'b1;
        step();
        md_resultRDY = 1'b0;
        md_exception = 1'b0;
        check("t3_done_stall", stall, 32'd0);
        check("t3_wbv",   wb_valid, 32'd1);
        check("t3_wbreg", wb_reg, 32'd30);
        check("t3_wbdat", wb_data, 32'd4);
        check("t3_wbexc", wb_exception, 32'd1);
        step();
        check("t3_idle_wbv", wb_valid, 32'd0);

        // illegal op selects are ignored
        drive_issue(1'b1, 1'b1, 32'd5, 32'd5, 5'd1);
        #1;
        check("t4_both_stall", stall, 32'd0);
        step();
        check("t4_both_mult",  ctrl_MULT, 32'd0);
        check("t4_both_div",   ctrl_DIV, 32'd0);
        check("t4_both_stall2", stall, 32'd0);
        check("t4_both_opA",   md_operandA, 32'h4000_0000);
        drive_issue(1'b0, 1'b0, 32'd8, 32'd8, 5'd1);
        #1;
        check("t4_none_stall", stall, 32'd0);
        step();
        check("t4_none_mult", ctrl_MULT, 32'd0);
        check("t4_none_div",  ctrl_DIV, 32'd0);
        check("t4_none_opA",  md_operandA, 32'h4000_0000);
        issue_valid = 1'b0;

        // reset in the middle of BUSY abandons the operation
        drive_issue(1'b1, 1'b0, 32'd3, 32'd3, 5'd2);
        step();
        issue_valid = 1'b0;
        step();
        check("t5_busy_stall", stall, 32'd1);
        clrn = 1'b0;
        #1;
        check("t5_rst_opA",   md_operandA, 32'd0);
        check("t5_rst_opB",   md_operandB, 32'd0);
        check("t5_rst_stall", stall, 32'd0);
        check("t5_rst_mult",  ctrl_MULT, 32'd0);
        check("t5_rst_wbv",   wb_valid, 32'd0);
        step();
        clrn         = 1'b1;
        md_resultRDY = 1'b1;
        md_result    = 32'd9;
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_post_wbv",  wb_valid, 32'd0);
            check("t5_post_mult", ctrl_MULT, 32'd0);
        end
        md_resultRDY = 1'b0;

`ifdef MD_TIMEOUT_EN
        begin
            int unsigned busy_cycles;
            busy_cycles = 0;
            drive_issue(1'b0, 1'b1, 32'd10, 32'd2, 5'd6);
            step();
            issue_valid = 1'b0;
            step();
            while (!wb_valid && busy_cycles < 200) begin
                step();
                busy_cycles++;
            end
            check("t6_busy_cycles", busy_cycles, 32'd64);
            check("t6_wbv",   wb_valid, 32'd1);
            check("t6_wbreg", wb_reg, 32'd30);
            check("t6_wbdat", wb_data, 32'd6);
            check("t6_wbexc", wb_exception, 32'd1);
            step();
            drive_issue(1'b1, 1'b0, 32'd2, 32'd3, 5'd5);
            #1;
            check("t6_b2b_stall", stall, 32'd1);
            step();
            issue_valid = 1'b0;
            check("t6_b2b_mult", ctrl_MULT, 32'd1);
            check("t6_b2b_opA",  md_operandA, 32'd2);
            step();
            md_resultRDY = 1'b1;
            md_result    = 32'd6;
            step();
            md_resultRDY = 1'b0;
            check("t6_b2b_wbreg", wb_reg, 32'd5);
            check("t6_b2b_wbdat", wb_data, 32'd6);
            check("t6_b2b_wbexc", wb_exception, 32'd0);
            step();
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
